// File: rtl/decoder_pkg.sv
// Shared mode encodings for the N-to-M decoder family.
// No logic; constants only.
// Imported by the combinational core and the registered top.
package decoder_pkg;

  localparam logic [1:0] MODE_ONE_HOT  = 2'b00;
  localparam logic [1:0] MODE_ONE_COLD = 2'b01;
  localparam logic [1:0] MODE_THERMO   = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

endpackage

// File: rtl/decoder_n_m_comb.sv
// Purpose: binary code to OUT_COUNT-line vector (one-hot / one-cold / thermometer) plus invalid flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing register stage owns the handshake.
module decoder_n_m_comb
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_COUNT = 8
) (
  input  logic [IN_WIDTH-1:0]  i_code,
  input  logic [1:0]           i_mode,
  output logic [OUT_COUNT-1:0] o_vector,
  output logic                 o_invalid
);

  if (IN_WIDTH < 1 || IN_WIDTH > 8) begin : g_bad_in_width
    $error("decoder_n_m_comb: IN_WIDTH must be 1..8");
  end
  if (OUT_COUNT < 2 || OUT_COUNT > (1 << IN_WIDTH)) begin : g_bad_out_count
    $error("decoder_n_m_comb: OUT_COUNT must be 2..2**IN_WIDTH");
  end

  // One extra bit so OUT_COUNT == 2**IN_WIDTH is representable and never flags.
  localparam logic [IN_WIDTH:0] LP_COUNT = (IN_WIDTH+1)'(OUT_COUNT);

  logic [IN_WIDTH:0]  w_code;
  logic               w_range_err;
  logic [OUT_COUNT-1:0] w_hot;
  logic [OUT_COUNT-1:0] w_thermo;

  assign w_code      = {1'b0, i_code};
  assign w_range_err = (w_code >= LP_COUNT);
  assign o_invalid   = w_range_err | (i_mode == MODE_RSVD);

  // Compare every line index with the code to form one-hot and thermometer patterns
  always_comb begin
    w_hot    = '0;
    w_thermo = '0;
    for (int i = 0; i < OUT_COUNT; i++) begin
      w_hot[i]    = ((IN_WIDTH+1)'(i) == w_code);
      w_thermo[i] = ((IN_WIDTH+1)'(i) <= w_code);
    end
  end

  // Select the pattern for the mode; invalid inputs give the mode's idle level
  always_comb begin
    o_vector = '0;
    if (o_invalid) begin
      o_vector = (i_mode == MODE_ONE_COLD) ? {OUT_COUNT{1'b1}} : {OUT_COUNT{1'b0}};
    end else begin
      case (i_mode)
        MODE_ONE_HOT:  o_vector = w_hot;
        MODE_ONE_COLD: o_vector = ~w_hot;
        MODE_THERMO:   o_vector = w_thermo;
        default:       o_vector = '0;
      endcase
    end
  end

endmodule

// File: rtl/decoder_n_m_pipelined.sv
// Purpose: registered decoder with valid/ready on both sides and a saturating invalid-transaction counter.
// Latency: exactly 1 cycle from accept to Valid_Out; full throughput of 1 per cycle.
// Backpressure: Ready_Out = Enable_In & (~Valid_Out | Ready_In); a stalled output holds stable.
module decoder_n_m_pipelined
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_COUNT = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock_In,
  input  logic                 Reset_In,
  input  logic                 Enable_In,
  input  logic                 Valid_In,
  output logic                 Ready_Out,
  input  logic [IN_WIDTH-1:0]  Encoded_Value_In,
  input  logic [1:0]           Mode_In,
  output logic                 Valid_Out,
  input  logic                 Ready_In,
  output logic [OUT_COUNT-1:0] Decoded_Value_Out,
  output logic                 Range_Error_Out,
  output logic [CNT_WIDTH-1:0] Error_Count_Out
);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("decoder_n_m_pipelined: CNT_WIDTH must be at least 1");
  end

  logic                 r_valid;
  logic [OUT_COUNT-1:0] r_vector;
  logic                 r_range_err;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  logic [OUT_COUNT-1:0] w_vector;
  logic                 w_invalid;
  logic                 w_ready;
  logic                 w_accept;

  decoder_n_m_comb #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_COUNT (OUT_COUNT)
  ) u_comb (
    .i_code    (Encoded_Value_In),
    .i_mode    (Mode_In),
    .o_vector  (w_vector),
    .o_invalid (w_invalid)
  );

  assign w_ready  = Enable_In & (~r_valid | Ready_In);
  assign w_accept = Valid_In & w_ready;

  // Output stage: load on accept, clear valid on consume, otherwise hold; reset drops pending data
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_valid     <= 1'b0;
      r_vector    <= '0;
      r_range_err <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_vector    <= w_vector;
      r_range_err <= w_invalid;
    end else if (Ready_In) begin
      r_valid     <= 1'b0;
    end
  end

  // Count accepted invalid transactions, sticking at all-ones
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_invalid && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
    end
  end

  assign Ready_Out         = w_ready;
  assign Valid_Out         = r_valid;
  assign Decoded_Value_Out = r_vector;
  assign Range_Error_Out   = r_range_err;
  assign Error_Count_Out   = r_err_cnt;

endmodule

// File: tb/tb_decoder_n_m_pipelined.sv
// Directed bench: d0 uses default parameters, d1 uses OUT_COUNT=6, CNT_WIDTH=2.
// Table-driven back-to-back vectors plus hand-written stall, reset and enable sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_decoder_n_m_pipelined;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] code;
    logic [7:0] vec;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst    [2];
  logic       en     [2];
  logic       vin    [2];
  logic       rdy_in [2];
  logic [2:0] code   [2];
  logic [1:0] mode   [2];
  logic       rdy_o  [2];
  logic       vout   [2];
  logic       err_o  [2];
  logic [7:0] dec_o  [2];
  logic [7:0] cnt_o  [2];

  logic [7:0] vec0;
  logic [7:0] cnt0;
  logic [5:0] vec1;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  decoder_n_m_pipelined d0 (
    .Clock_In          (clk),
    .Reset_In          (rst[0]),
    .Enable_In         (en[0]),
    .Valid_In          (vin[0]),
    .Ready_Out         (rdy_o[0]),
    .Encoded_Value_In  (code[0]),
    .Mode_In           (mode[0]),
    .Valid_Out         (vout[0]),
    .Ready_In          (rdy_in[0]),
    .Decoded_Value_Out (vec0),
    .Range_Error_Out   (err_o[0]),
    .Error_Count_Out   (cnt0)
  );

  decoder_n_m_pipelined #(.IN_WIDTH(3), .OUT_COUNT(6), .CNT_WIDTH(2)) d1 (
    .Clock_In          (clk),
    .Reset_In          (rst[1]),
    .Enable_In         (en[1]),
    .Valid_In          (vin[1]),
    .Ready_Out         (rdy_o[1]),
    .Encoded_Value_In  (code[1]),
    .Mode_In           (mode[1]),
    .Valid_Out         (vout[1]),
    .Ready_In          (rdy_in[1]),
    .Decoded_Value_Out (vec1),
    .Range_Error_Out   (err_o[1]),
    .Error_Count_Out   (cnt1)
  );

  assign dec_o[0] = vec0;
  assign cnt_o[0] = cnt0;
  assign dec_o[1] = {2'b00, vec1};
  assign cnt_o[1] = {6'b0, cnt1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic [2:0] c, input logic [7:0] v,
                     input logic e, input logic [7:0] n);
    vec_t t;
    t.mode = m; t.code = c; t.vec = v; t.err = e; t.cnt = n;
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [1:0] m, input logic [2:0] c);
    vin[d] = v; mode[d] = m; code[d] = c;
  endtask

  // Back-to-back vectors with Ready_In=1: each result must appear exactly one edge later
  task automatic run_table(input int d);
    en[d] = 1'b1;
    rdy_in[d] = 1'b1;
    drive(d, 1'b1, tbl[0].mode, tbl[0].code);
    for (int k = 0; k < tbl.size(); k++) begin
      tick();
      chk($sformatf("d%0d tbl%0d valid", d, k), vout[d], 1'b1);
      chk($sformatf("d%0d tbl%0d vec", d, k), dec_o[d], tbl[k].vec);
      chk($sformatf("d%0d tbl%0d err", d, k), err_o[d], tbl[k].err);
      chk($sformatf("d%0d tbl%0d cnt", d, k), cnt_o[d], tbl[k].cnt);
      if (k + 1 < tbl.size()) drive(d, 1'b1, tbl[k+1].mode, tbl[k+1].code);
      else                    drive(d, 1'b0, 2'b00, 3'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b1; vin[d] = 1'b0; rdy_in[d] = 1'b1;
      code[d] = '0; mode[d] = '0;
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset valid", d), vout[d], 1'b0);
      chk($sformatf("d%0d reset vec", d), dec_o[d], 8'h00);
      chk($sformatf("d%0d reset err", d), err_o[d], 1'b0);
      chk($sformatf("d%0d reset cnt", d), cnt_o[d], 8'h00);
    end

    // d0: one-hot sweep, thermometer, one-cold and reserved mode
    tbl.delete();
    for (int c = 0; c < 8; c++) add(2'b00, 3'(c), 8'(1 << c), 1'b0, 8'd0);
    add(2'b10, 3'd3, 8'h0F, 1'b0, 8'd0);
    add(2'b10, 3'd7, 8'hFF, 1'b0, 8'd0);
    add(2'b10, 3'd0, 8'h01, 1'b0, 8'd0);
    add(2'b11, 3'd2, 8'h00, 1'b1, 8'd1);
    add(2'b01, 3'd2, 8'hFB, 1'b0, 8'd1);
    run_table(0);
    tick();
    chk("d0 drain valid", vout[0], 1'b0);

    // d0 stall: code 5 held for 5 cycles while inputs change, then consumed once
    rdy_in[0] = 1'b0;
    drive(0, 1'b1, 2'b00, 3'd5);
    tick();
    drive(0, 1'b1, 2'b10, 3'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d valid", i), vout[0], 1'b1);
      chk($sformatf("stall%0d vec", i), dec_o[0], 8'h20);
      chk($sformatf("stall%0d ready", i), rdy_o[0], 1'b0);
      tick();
    end
    drive(0, 1'b0, 2'b00, 3'd0);
    rdy_in[0] = 1'b1;
    #1;
    chk("release ready", rdy_o[0], 1'b1);
    chk("release vec", dec_o[0], 8'h20);
    tick();
    chk("consumed valid", vout[0], 1'b0);
    chk("consumed vec hold", dec_o[0], 8'h20);

    // d0: held output drains with Enable_In=0, nothing new accepted
    rdy_in[0] = 1'b0;
    drive(0, 1'b1, 2'b00, 3'd4);
    tick();
    chk("en-drain loaded", dec_o[0], 8'h10);
    en[0] = 1'b0;
    rdy_in[0] = 1'b1;
    drive(0, 1'b1, 2'b00, 3'd6);
    #1;
    chk("en0 ready", rdy_o[0], 1'b0);
    tick();
    chk("en0 drained valid", vout[0], 1'b0);
    tick();
    chk("en0 no accept", vout[0], 1'b0);
    chk("en0 vec hold", dec_o[0], 8'h10);
    en[0] = 1'b1;

    // d0: reset while stalled drops the pending output
    rdy_in[0] = 1'b0;
    drive(0, 1'b1, 2'b00, 3'd3);
    tick();
    chk("pre-rst valid", vout[0], 1'b1);
    chk("pre-rst vec", dec_o[0], 8'h08);
    chk("pre-rst cnt", cnt_o[0], 8'd1);
    drive(0, 1'b0, 2'b00, 3'd0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("rst valid", vout[0], 1'b0);
    chk("rst vec", dec_o[0], 8'h00);
    chk("rst cnt", cnt_o[0], 8'd0);
    rdy_in[0] = 1'b1;
    tick();
    chk("rst not delivered", vout[0], 1'b0);

    // d1: OUT_COUNT=6 range errors and 2-bit counter saturation
    tbl.delete();
    add(2'b00, 3'd6, 8'h00, 1'b1, 8'd1);
    add(2'b01, 3'd6, 8'h3F, 1'b1, 8'd2);
    add(2'b10, 3'd7, 8'h00, 1'b1, 8'd3);
    add(2'b11, 3'd2, 8'h00, 1'b1, 8'd3);
    add(2'b00, 3'd6, 8'h00, 1'b1, 8'd3);
    add(2'b10, 3'd5, 8'h3F, 1'b0, 8'd3);
    add(2'b01, 3'd5, 8'h1F, 1'b0, 8'd3);
    add(2'b00, 3'd5, 8'h20, 1'b0, 8'd3);
    run_table(1);

    // d1: Enable_In=0 blocks acceptance until it returns
    en[1] = 1'b0;
    drive(1, 1'b1, 2'b00, 3'd1);
    #1;
    chk("d1 en0 ready", rdy_o[1], 1'b0);
    tick();
    chk("d1 en0 valid", vout[1], 1'b0);
    tick();
    chk("d1 en0 still idle", vout[1], 1'b0);
    chk("d1 en0 cnt", cnt_o[1], 8'd3);
    en[1] = 1'b1;
    #1;
    chk("d1 en1 ready", rdy_o[1], 1'b1);
    tick();
    chk("d1 en1 valid", vout[1], 1'b1);
    chk("d1 en1 vec", dec_o[1], 8'h02);
    drive(1, 1'b0, 2'b00, 3'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
